// File: rtl/loader_pkg.sv
// Shared definitions for the IMEM boot loader.
// Holds the FSM state encoding, frame layout constants and the checksum
// update helper used by imem_loader and word_assembler.
package loader_pkg;

  // Loader FSM states.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  // Frame layout: 2-byte word count, payload words, 1-byte XOR checksum.
  localparam int HDR_BYTES      = 2;
  localparam int CSUM_BYTES     = 1;
  localparam int BYTES_PER_WORD = 4;

  // Running XOR checksum over payload bytes.
  function automatic logic [7:0] csum_update(input logic [7:0] acc,
                                             input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Little-endian byte-to-word packer.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   clear        - restart byte position at 0 (new frame)
//   byte_valid   - a payload byte is accepted this cycle
//   byte_data    - the payload byte
//   word_last    - combinational: this accepted byte completes a word
//   word_valid   - registered one-cycle pulse, word is complete
//   word         - assembled word (first byte in bits [7:0]); holds its value
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_last,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0] byte_idx;

  assign word_last = byte_valid && (byte_idx == 2'(BYTES_PER_WORD - 1));

  // Byte position counter, byte lane insertion and completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx   <= 2'd0;
      word_valid <= 1'b0;
      word       <= 32'd0;
    end else begin
      word_valid <= word_last;
      if (clear) begin
        // The word register is kept so the IMEM data bus holds its last value.
        byte_idx <= 2'd0;
      end else if (byte_valid) begin
        byte_idx                      <= byte_idx + 2'd1;
        word[{byte_idx, 3'b000} +: 8] <= byte_data;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader for the pipeline instruction memory.
// Frame: 16-bit little-endian word count, little-endian 32-bit payload
// words, then one XOR checksum byte over the payload.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   start                         - begin a load (only in IDLE/DONE/ERR)
//   in_valid, in_data, in_ready   - byte stream, transfer = in_valid & in_ready
//   imem_we, imem_addr, imem_wdata - IMEM write port, one strobe per word
//   core_rst_n                    - core reset, released only after a good image
//   busy, done, error             - load status; done/error held until next start
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  // Largest word count that fits between BASE_ADDR and the top of IMEM.
  localparam logic [16:0] MAX_WORDS = 17'((1 << ADDR_WIDTH) - BASE_ADDR);

  state_t      state;
  logic [15:0] count;
  logic [15:0] word_idx;
  logic [7:0]  csum;

  logic        accept;
  logic        start_ok;
  logic        pay_valid;
  logic        word_last;
  logic        word_valid;
  logic [31:0] word;
  logic [16:0] count_full;

  // No byte is taken in the write cycle so the write never overlaps a new byte.
  assign in_ready = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                    (state == S_CHECK)  || ((state == S_DATA) && !word_valid);
  assign busy     = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                    (state == S_DATA)   || (state == S_CHECK);

  assign accept     = in_valid && in_ready;
  assign start_ok   = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  assign pay_valid  = accept && (state == S_DATA);
  assign count_full = {1'b0, in_data, count[7:0]};

  assign imem_we    = word_valid;
  assign imem_wdata = word;

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok),
    .byte_valid (pay_valid),
    .byte_data  (in_data),
    .word_last  (word_last),
    .word_valid (word_valid),
    .word       (word)
  );

  // Loader FSM with word counter, checksum accumulator and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      count      <= 16'd0;
      word_idx   <= 16'd0;
      csum       <= 8'd0;
      imem_addr  <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      core_rst_n <= 1'b0;
    end else begin
      // Address is latched with the last byte so it lines up with the strobe.
      if (word_last) begin
        imem_addr <= ADDR_WIDTH'(BASE_ADDR + int'(word_idx));
      end
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state      <= S_LEN_LO;
            done       <= 1'b0;
            error      <= 1'b0;
            core_rst_n <= 1'b0;
            count      <= 16'd0;
            word_idx   <= 16'd0;
            csum       <= 8'd0;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            count[7:0] <= in_data;
            state      <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            count[15:8] <= in_data;
            if (count_full > MAX_WORDS) begin
              state <= S_ERR;
              error <= 1'b1;
            end else if (count_full == 17'd0) begin
              state <= S_CHECK;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (pay_valid) begin
            csum <= csum_update(csum, in_data);
          end
          if (word_valid) begin
            word_idx <= word_idx + 16'd1;
            if ((word_idx + 16'd1) == count) begin
              state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (accept) begin
            if (in_data == csum) begin
              state      <= S_DONE;
              done       <= 1'b1;
              core_rst_n <= 1'b1;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
